// File: rtl/vproc_pkg.sv
// Shared types and constants for the vector-processor hazard scoreboard.
package vproc_pkg;

    localparam int unsigned SB_VREG_CNT = 32;

    typedef struct packed {
        logic                   valid;
        logic [SB_VREG_CNT-1:0] rd;
        logic [SB_VREG_CNT-1:0] wr;
    } sb_slot_t;

    function automatic logic masks_overlap(input logic [SB_VREG_CNT-1:0] a,
                                           input logic [SB_VREG_CNT-1:0] b);
        return |(a & b);
    endfunction

endpackage

// File: rtl/vproc_hazard_scoreboard_if.sv
// Issue handshake between the hazard-mask generator, the scoreboard and the execution units.
interface vproc_hazard_scoreboard_if
    import vproc_pkg::*;
#(
    parameter int unsigned ID_CNT = 4,
    parameter int unsigned OP_W   = 64
);
    localparam int unsigned ID_W = $clog2(ID_CNT);

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [OP_W-1:0]        in_op_i;
    logic [SB_VREG_CNT-1:0] in_rd_hazards_i;
    logic [SB_VREG_CNT-1:0] in_wr_hazards_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [OP_W-1:0]        out_op_o;
    logic [ID_W-1:0]        out_id_o;

    modport master (
        output in_valid_i, in_op_i, in_rd_hazards_i, in_wr_hazards_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_op_o, out_id_o
    );

    modport slave (
        input  in_valid_i, in_op_i, in_rd_hazards_i, in_wr_hazards_i, out_ready_i,
        output in_ready_o, out_valid_o, out_op_o, out_id_o
    );

endinterface

// File: rtl/vproc_sb_slot.sv
// One scoreboard slot: allocation beats retire, retire beats a partial read clear.
module vproc_sb_slot
    import vproc_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   async_rst_ni,
    input  logic                   alloc_i,
    input  logic [SB_VREG_CNT-1:0] alloc_rd_i,
    input  logic [SB_VREG_CNT-1:0] alloc_wr_i,
    input  logic                   rd_clr_i,
    input  logic [SB_VREG_CNT-1:0] rd_clr_mask_i,
    input  logic                   retire_i,
    output sb_slot_t               slot_o
);

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            slot_o <= '0;
        end else if (alloc_i) begin
            slot_o <= {1'b1, alloc_rd_i, alloc_wr_i};
        end else if (retire_i) begin
            slot_o <= '0;
        end else if (rd_clr_i && slot_o.valid) begin
            slot_o.rd <= slot_o.rd & ~rd_clr_mask_i;
        end
    end

endmodule

// File: rtl/vproc_hazard_scoreboard.sv
// Issue-stage RAW/WAR/WAW scoreboard with in-order tag allocation.
// Optional macro VPROC_SB_BYPASS_EN lets this cycle's releases unblock issue combinationally.
module vproc_hazard_scoreboard
    import vproc_pkg::*;
#(
    parameter  int unsigned ID_CNT = 4,
    parameter  int unsigned OP_W   = 64,
    localparam int unsigned ID_W   = $clog2(ID_CNT)
) (
    input  logic                   clk_i,
    input  logic                   async_rst_ni,
    vproc_hazard_scoreboard_if.slave sb,
    input  logic                   rd_clr_valid_i,
    input  logic [ID_W-1:0]        rd_clr_id_i,
    input  logic [SB_VREG_CNT-1:0] rd_clr_mask_i,
    input  logic                   retire_valid_i,
    input  logic [ID_W-1:0]        retire_id_i,
    output logic [SB_VREG_CNT-1:0] pend_rd_o,
    output logic [SB_VREG_CNT-1:0] pend_wr_o,
    output logic                   idle_o
);

    sb_slot_t               slots [ID_CNT];
    logic [ID_CNT-1:0]      alloc_hit, clr_hit, ret_hit, slot_busy, slot_valid;
    logic [SB_VREG_CNT-1:0] pend_rd, pend_wr, chk_rd, chk_wr;
    logic [ID_W-1:0]        alloc_ptr;
    logic                   conflict, slot_free, issue, fire;

    always_comb begin
        alloc_hit = '0;
        clr_hit   = '0;
        ret_hit   = '0;
        for (int unsigned k = 0; k < ID_CNT; k++) begin
            alloc_hit[k] = fire && (alloc_ptr == ID_W'(k));
            clr_hit[k]   = rd_clr_valid_i && (rd_clr_id_i == ID_W'(k));
            ret_hit[k]   = retire_valid_i && (retire_id_i == ID_W'(k));
        end
    end

    for (genvar g = 0; g < ID_CNT; g++) begin : g_slot
        vproc_sb_slot u_slot (
            .clk_i         (clk_i),
            .async_rst_ni  (async_rst_ni),
            .alloc_i       (alloc_hit[g]),
            .alloc_rd_i    (sb.in_rd_hazards_i),
            .alloc_wr_i    (sb.in_wr_hazards_i),
            .rd_clr_i      (clr_hit[g]),
            .rd_clr_mask_i (rd_clr_mask_i),
            .retire_i      (ret_hit[g]),
            .slot_o        (slots[g])
        );
    end

    // pend_* reflect registered state; chk_* is what the conflict check sees
    always_comb begin
        pend_rd    = '0;
        pend_wr    = '0;
        chk_rd     = '0;
        chk_wr     = '0;
        slot_busy  = '0;
        slot_valid = '0;
        for (int unsigned k = 0; k < ID_CNT; k++) begin
            slot_valid[k] = slots[k].valid;
            if (slots[k].valid) begin
                pend_rd |= slots[k].rd;
                pend_wr |= slots[k].wr;
            end
`ifdef VPROC_SB_BYPASS_EN
            if (slots[k].valid && !ret_hit[k]) begin
                chk_rd |= slots[k].rd & ~(clr_hit[k] ? rd_clr_mask_i : '0);
                chk_wr |= slots[k].wr;
                slot_busy[k] = 1'b1;
            end
`else
            if (slots[k].valid) begin
                chk_rd |= slots[k].rd;
                chk_wr |= slots[k].wr;
                slot_busy[k] = 1'b1;
            end
`endif
        end
    end

    assign conflict = masks_overlap(sb.in_rd_hazards_i, chk_wr)
                    | masks_overlap(sb.in_wr_hazards_i, chk_wr)
                    | masks_overlap(sb.in_wr_hazards_i, chk_rd);
    assign slot_free = !slot_busy[alloc_ptr];
    assign issue     = sb.in_valid_i && slot_free && !conflict;
    assign fire      = issue && sb.out_ready_i;

    assign sb.out_valid_o = issue;
    assign sb.in_ready_o  = fire;
    assign sb.out_op_o    = OP_W'(sb.in_op_i);
    assign sb.out_id_o    = alloc_ptr;

    assign pend_rd_o = pend_rd;
    assign pend_wr_o = pend_wr;
    assign idle_o    = ~|slot_valid;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            alloc_ptr <= '0;
        end else if (fire) begin
            alloc_ptr <= alloc_ptr + ID_W'(1);
        end
    end

endmodule
